// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Takes single-cycle byte strobes from the store path and queues them in a
// DEPTH-entry FIFO. A serializer with its own baud counter drains the FIFO
// one frame at a time: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Between back-to-back frames the line is high for exactly one IDLE cycle.
//
// state | meaning
// IDLE  | line high, not busy; pops the head byte when the FIFO is not empty
// START | start bit (line low) for BAUD_DIV cycles
// DATA  | eight data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (line high) for BAUD_DIV cycles, then back to IDLE
module uart_tx_fifo #(
   parameter int BAUD_DIV = 868,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              uart_tx,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              overflow
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_nxt;
   logic              push;
   logic              pop;

   state_t            state;
   logic [CNT_W-1:0]  baud_cnt;
   logic              baud_tick;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;

   // A push is accepted only against the registered full flag, so a pop in
   // the same cycle never makes room for a push that found the FIFO full.
   assign push      = wr_en && !full;
   assign pop       = (state == IDLE) && !empty;
   assign baud_tick = (baud_cnt == BAUD_LAST);

   // Next occupancy from the push/pop pair; simultaneous push and pop cancel.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and flags, all registered so they always agree.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);
         empty <= (count_nxt == '0);
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Serializer: one flop drives the line so it cannot glitch between bits.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               uart_tx <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  baud_cnt <= '0;
                  state    <= START;
                  uart_tx  <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  uart_tx  <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            DATA: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            STOP: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               uart_tx <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with BAUD_DIV=4, DEPTH=16.
// Reference model: a byte queue plus a "cycles left in current frame" timer;
// the expected line level is derived from the elapsed position in the frame.
module tb_uart_tx_fifo;

   localparam int B  = 4;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          uart_tx;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          busy;
   logic          overflow;

   int vectors = 0;
   int miscompares = 0;

   uart_tx_fifo #(.BAUD_DIV(B), .DEPTH(D), .ADDR_W(AW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .uart_tx  (uart_tx),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 CLK = ~CLK;

   wire [9:0] dut_status = {uart_tx, busy, full, empty, overflow, count};

   // reference model state
   logic [7:0] m_q[$];
   logic [7:0] m_sent[$];
   int         m_left;
   logic [7:0] m_cur;
   logic       m_ovf;

   // bytes recovered from the line
   logic [7:0] rx_q[$];
   int         rx_ferr;
   logic       mon_prev;
   logic [9:0] mon_bits;
   bit         mon_abort;

   function automatic logic [9:0] exp_status();
      logic        tx;
      int          el;
      int          slot;
      int          sz;
      logic [AW:0] cnt;
      tx = 1'b1;
      if (m_left > 0) begin
         el   = 10*B - m_left;
         slot = el / B;
         if (slot == 0)      tx = 1'b0;
         else if (slot <= 8) tx = m_cur[slot-1];
      end
      sz  = m_q.size();
      cnt = sz[AW:0];
      return {tx, (m_left > 0), (sz == D), (sz == 0), m_ovf, cnt};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_left = 0;
      m_cur  = 8'h00;
      m_ovf  = 1'b0;
   endtask

   task automatic model_edge(input logic we, input logic [7:0] d);
      bit do_pop;
      bit do_push;
      do_pop  = (m_left == 0) && (m_q.size() > 0);
      do_push = we && (m_q.size() < D);
      if (we && m_q.size() == D) m_ovf = 1'b1;
      if (m_left > 0) m_left--;
      if (do_pop) begin
         m_cur  = m_q.pop_front();
         m_left = 10*B;
         m_sent.push_back(m_cur);
      end
      if (do_push) m_q.push_back(d);
   endtask

   task automatic tick(input logic we, input logic [7:0] d);
      wr_en   = we;
      wr_data = d;
      @(posedge CLK);
      if (RST) model_reset();
      else     model_edge(we, d);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      RST = 1'b0;
      model_reset();
      m_sent.delete();
      rx_q.delete();
      rx_ferr = 0;
   endtask

   // Line decoder: after a falling edge, sample each bit at its midpoint.
   initial begin : rx_mon
      mon_prev = 1'b1;
      forever begin
         @(negedge CLK);
         if (RST) begin
            mon_prev = 1'b1;
         end else if (mon_prev && !uart_tx) begin
            mon_abort = 1'b0;
            for (int k = 0; k < 10; k++) begin
               repeat ((k == 0) ? B/2 : B) begin
                  @(negedge CLK);
                  if (RST) mon_abort = 1'b1;
               end
               mon_bits[k] = uart_tx;
            end
            if (!mon_abort) begin
               if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) rx_ferr++;
               rx_q.push_back(mon_bits[8:1]);
            end
            mon_prev = uart_tx;
         end else begin
            mon_prev = uart_tx;
         end
      end
   end

   task automatic test_reset();
      RST = 1'b1;
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      vectors++;
      if (dut_status !== 10'b1_0_0_1_0_00000) begin
         miscompares++;
         $display("FAIL reset_values: got %b expected %b", dut_status, 10'b1_0_0_1_0_00000);
      end
      RST = 1'b0;
      model_reset();
      repeat (100) begin
         tick(1'b0, 8'h00);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL reset_idle t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
   endtask

   task automatic test_single();
      int busy_cycles;
      do_reset();
      tick(1'b1, 8'hA5);
      vectors++;
      if (uart_tx !== 1'b1) begin
         miscompares++;
         $display("FAIL single_latency_push_edge: got %b expected 1", uart_tx);
      end
      tick(1'b0, 8'h00);
      vectors++;
      if (uart_tx !== 1'b0) begin
         miscompares++;
         $display("FAIL single_latency_fall: got %b expected 0", uart_tx);
      end
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      repeat (45) begin
         tick(1'b0, 8'h00);
         if (busy === 1'b1) busy_cycles++;
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL single_frame t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      vectors++;
      if (busy_cycles != 10*B) begin
         miscompares++;
         $display("FAIL single_frame_len: got %0d expected %0d", busy_cycles, 10*B);
      end
      vectors++;
      if (busy !== 1'b0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL single_after: got busy=%b empty=%b expected busy=0 empty=1", busy, empty);
      end
      vectors++;
      if (rx_q.size() != 1 || rx_ferr != 0 || (rx_q.size() == 1 && rx_q[0] !== 8'hA5)) begin
         miscompares++;
         $display("FAIL single_decode: got %0d frames (ferr %0d) expected one frame of a5", rx_q.size(), rx_ferr);
      end
   endtask

   task automatic test_back_to_back();
      int peak;
      int gaps;
      bit started;
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
      do_reset();
      peak = 0; gaps = 0; started = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, exp_b[i]);
         if (int'(count) > peak) peak = int'(count);
      end
      for (int i = 0; i < 500 && (m_left > 0 || m_q.size() > 0); i++) begin
         tick(1'b0, 8'h00);
         if (int'(count) > peak) peak = int'(count);
         if (busy === 1'b1) started = 1;
         if (started && busy === 1'b0 && m_q.size() > 0) gaps++;
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL b2b_cycle t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      repeat (3) tick(1'b0, 8'h00);
      vectors++;
      if (peak < 2 || peak > 3) begin
         miscompares++;
         $display("FAIL b2b_peak: got %0d expected 2 or 3", peak);
      end
      vectors++;
      if (gaps != 2) begin
         miscompares++;
         $display("FAIL b2b_idle_gaps: got %0d expected 2", gaps);
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_overflow: got %b expected 0", overflow);
      end
      vectors++;
      if (rx_q.size() != 3 || rx_ferr != 0) begin
         miscompares++;
         $display("FAIL b2b_frames: got %0d frames (ferr %0d) expected 3", rx_q.size(), rx_ferr);
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rx_q[i] !== exp_b[i]) begin
               miscompares++;
               $display("FAIL b2b_order[%0d]: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
         end
      end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] pushed[$];
      logic [7:0] b;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom);
         pushed.push_back(b);
         tick(1'b1, b);
      end
      vectors++;
      if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: got count=%0d full=%b ovf=%b expected 16 1 0", count, full, overflow);
      end
      tick(1'b1, 8'hEE);
      tick(1'b1, 8'hDD);
      vectors++;
      if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_overflow: got count=%0d full=%b ovf=%b expected 16 1 1", count, full, overflow);
      end
      for (int i = 0; i < 17*(10*B+1) + 50 && (m_left > 0 || m_q.size() > 0); i++) begin
         tick(1'b0, 8'h00);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL fill_cycle t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      repeat (3) tick(1'b0, 8'h00);
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_ovf_sticky: got %b expected 1", overflow);
      end
      vectors++;
      if (rx_q.size() != 17 || rx_ferr != 0) begin
         miscompares++;
         $display("FAIL fill_frames: got %0d frames (ferr %0d) expected 17", rx_q.size(), rx_ferr);
      end else begin
         for (int i = 0; i < 17; i++) begin
            vectors++;
            if (rx_q[i] !== pushed[i]) begin
               miscompares++;
               $display("FAIL fill_order[%0d]: got %h expected %h", i, rx_q[i], pushed[i]);
            end
         end
      end
   endtask

   task automatic test_push_pop_same();
      do_reset();
      tick(1'b1, 8'h3C);
      tick(1'b1, 8'hC3);
      vectors++;
      if (count !== 5'd1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL push_pop_same: got count=%0d busy=%b expected 1 1", count, busy);
      end
      for (int i = 0; i < 200 && (m_left > 0 || m_q.size() > 0); i++) begin
         tick(1'b0, 8'h00);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL push_pop_cycle t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      repeat (3) tick(1'b0, 8'h00);
      vectors++;
      if (rx_q.size() != 2 || (rx_q.size() == 2 && (rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3))) begin
         miscompares++;
         $display("FAIL push_pop_frames: got %0d frames expected 3c c3", rx_q.size());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] pushed[$];
      logic [7:0] b;
      do_reset();
      while (pushed.size() < 40) begin
         if (m_q.size() < D) begin
            b = 8'($urandom);
            pushed.push_back(b);
            tick(1'b1, b);
         end else begin
            tick(1'b0, 8'h00);
         end
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL wrap_push t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
         repeat ($urandom_range(0, 5)) tick(1'b0, 8'h00);
      end
      for (int i = 0; i < 20*(10*B+1) + 50 && (m_left > 0 || m_q.size() > 0); i++) begin
         tick(1'b0, 8'h00);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL wrap_cycle t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      repeat (3) tick(1'b0, 8'h00);
      vectors++;
      if (rx_q.size() != 40 || rx_ferr != 0) begin
         miscompares++;
         $display("FAIL wrap_frames: got %0d frames (ferr %0d) expected 40", rx_q.size(), rx_ferr);
      end else begin
         for (int i = 0; i < 40; i++) begin
            vectors++;
            if (rx_q[i] !== pushed[i]) begin
               miscompares++;
               $display("FAIL wrap_order[%0d]: got %h expected %h", i, rx_q[i], pushed[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      tick(1'b1, 8'h00);
      repeat (5) tick(1'b1, 8'($urandom));
      repeat (4) tick(1'b0, 8'h00);
      vectors++;
      if (uart_tx !== 1'b0 || count !== 5'd5 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_pre: got tx=%b count=%0d busy=%b expected 0 5 1", uart_tx, count, busy);
      end
      #2;
      RST = 1'b1;
      #1;
      vectors++;
      if (uart_tx !== 1'b1 || count !== 5'd0 || busy !== 1'b0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_async: got tx=%b count=%0d busy=%b empty=%b expected 1 0 0 1",
                  uart_tx, count, busy, empty);
      end
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      RST = 1'b0;
      model_reset();
      repeat (200) begin
         tick(1'b0, 8'h00);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL rst_mid_after t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      vectors++;
      if (rx_q.size() != 0) begin
         miscompares++;
         $display("FAIL rst_mid_frames: got %0d frames expected 0", rx_q.size());
      end
   endtask

   task automatic test_random();
      do_reset();
      repeat (600) begin
         tick(($urandom_range(0, 2) == 0), 8'($urandom));
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL random_cycle t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      for (int i = 0; i < 20*(10*B+1) + 50 && (m_left > 0 || m_q.size() > 0); i++) begin
         tick(1'b0, 8'h00);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL random_drain t=%0t: got %b expected %b", $time, dut_status, exp_status());
         end
      end
      repeat (3) tick(1'b0, 8'h00);
      vectors++;
      if (rx_q.size() != m_sent.size() || rx_ferr != 0) begin
         miscompares++;
         $display("FAIL random_frames: got %0d frames (ferr %0d) expected %0d", rx_q.size(), rx_ferr, m_sent.size());
      end else begin
         for (int i = 0; i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== m_sent[i]) begin
               miscompares++;
               $display("FAIL random_order[%0d]: got %h expected %h", i, rx_q[i], m_sent[i]);
            end
         end
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      model_reset();
      rx_ferr = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_overflow();
      test_push_pop_same();
      test_wrap();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
